// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver oversampled by a baud_tick_16x strobe.
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   baud_tick_16x  one-clk strobe, OVERSAMPLE pulses per bit period
//   rx             asynchronous serial line, idle high
//   data           last good byte, held until the next good byte
//   data_valid     one-clk pulse when data has just been updated
//   frame_err      one-clk pulse when a stop bit was sampled low
//   busy           high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] MidStart = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] LastTick = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e                 state_q, state_d;
  logic [TickW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   rx_meta_q, rx_s;

  // Two-flop synchroniser; resets to the idle line level so no false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    // Strobes default low so they last exactly one clock.
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (baud_tick_16x) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d    = StStart;
            tick_cnt_d = '0;
          end
        end
        StStart: begin
          if (tick_cnt_q == MidStart) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = StData;
              bit_cnt_d = '0;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              state_d = StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
        StData: begin
          if (tick_cnt_q == LastTick) begin
            shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BitW'(1);
            if (bit_cnt_q == LastBit) begin
              state_d = StStop;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
        StStop: begin
          if (tick_cnt_q == LastTick) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              data_d       = shreg_q;
              data_valid_d = 1'b1;
              state_d      = StIdle;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StBreak;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
        StBreak: begin
          // Wait for the line to return high so a held-low line reports once.
          if (rx_s) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (OVERSAMPLE=16, tick every 4th clk).
module tb_uart_rx;

  localparam int BitClks = 64;  // 16 ticks x 4 clks

  logic       clk;
  logic       rst_n;
  logic       baud_tick_16x;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, written only by the monitor process.
  int         vcnt = 0;
  int         ecnt = 0;
  int         both = 0;
  logic [7:0] got[$];

  uart_rx #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_tick_16x(baud_tick_16x),
    .rx           (rx),
    .data         (data),
    .data_valid   (data_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    logic [1:0] div;
    div           = 2'd0;
    baud_tick_16x = 1'b0;
    forever begin
      @(negedge clk);
      baud_tick_16x = (div == 2'd3);
      div           = div + 2'd1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (data_valid) begin
        vcnt = vcnt + 1;
        got.push_back(data);
      end
      if (frame_err) ecnt = ecnt + 1;
      if (data_valid && frame_err) both = both + 1;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clks(BitClks);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BitClks);
    end
    rx = stop;
    wait_clks(BitClks);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rx    = 1'b1;
    rst_n = 1'b0;
    wait_clks(3);
    n_checks++;
    if (data !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %h want 00", data);
    end
    n_checks++;
    if (data_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_data_valid: got %b want 0", data_valid);
    end
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    rst_n = 1'b1;
    wait_clks(BitClks);
  endtask

  task automatic test_good_byte();
    int v0, e0, q0;
    v0 = vcnt; e0 = ecnt; q0 = got.size();
    send_frame(8'h48, 1'b1);
    wait_clks(8);
    n_checks++;
    if (vcnt - v0 !== 1) begin
      n_fail++; $display("FAIL good_valid_count: got %0d want 1", vcnt - v0);
    end
    n_checks++;
    if (got.size() > q0 ? got[q0] !== 8'h48 : 1'b1) begin
      n_fail++; $display("FAIL good_byte: got size %0d want byte 48", got.size() - q0);
    end
    n_checks++;
    if (data !== 8'h48) begin
      n_fail++; $display("FAIL good_data: got %h want 48", data);
    end
    n_checks++;
    if (ecnt - e0 !== 0) begin
      n_fail++; $display("FAIL good_frame_err: got %0d want 0", ecnt - e0);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL good_busy_after: got %b want 0", busy);
    end
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    rx = 1'b0;
    wait_clks(8);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL glitch_busy_start: got %b want 1", busy);
    end
    wait_clks(4);
    rx = 1'b1;
    wait_clks(32);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL glitch_busy_end: got %b want 0", busy);
    end
    n_checks++;
    if ((vcnt - v0) + (ecnt - e0) !== 0) begin
      n_fail++; $display("FAIL glitch_strobes: got %0d valid %0d err want 0 0",
                         vcnt - v0, ecnt - e0);
    end
    wait_clks(BitClks);
  endtask

  task automatic test_frame_err();
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    send_frame(8'hA5, 1'b0);
    wait_clks(BitClks);
    n_checks++;
    if (ecnt - e0 !== 1) begin
      n_fail++; $display("FAIL ferr_count: got %0d want 1", ecnt - e0);
    end
    n_checks++;
    if (vcnt - v0 !== 0) begin
      n_fail++; $display("FAIL ferr_valid: got %0d want 0", vcnt - v0);
    end
    n_checks++;
    if (data !== 8'h48) begin
      n_fail++; $display("FAIL ferr_data_kept: got %h want 48", data);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL ferr_idle: got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg[13];
    int v0, e0, q0;
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h55, 8'h41, 8'h52, 8'h54,
            8'h21, 8'h0A, 8'h0D};
    v0 = vcnt; e0 = ecnt; q0 = got.size();
    for (int i = 0; i < 13; i++) send_frame(msg[i], 1'b1);
    wait_clks(BitClks);
    n_checks++;
    if (vcnt - v0 !== 13) begin
      n_fail++; $display("FAIL b2b_count: got %0d want 13", vcnt - v0);
    end
    n_checks++;
    if (ecnt - e0 !== 0) begin
      n_fail++; $display("FAIL b2b_frame_err: got %0d want 0", ecnt - e0);
    end
    for (int i = 0; i < 13; i++) begin
      if (q0 + i < got.size()) begin
        n_checks++;
        if (got[q0 + i] !== msg[i]) begin
          n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got[q0 + i], msg[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, q0;
    rx = 1'b0;
    wait_clks(BitClks);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0);  // bits of 0x55, LSB first
      wait_clks(BitClks);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (data !== 8'h00) begin
      n_fail++; $display("FAIL rstmid_data: got %h want 00", data);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy);
    end
    n_checks++;
    if ({data_valid, frame_err} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_strobes: got %b want 00", {data_valid, frame_err});
    end
    rx = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(BitClks);
    v0 = vcnt; q0 = got.size();
    send_frame(8'h3C, 1'b1);
    wait_clks(8);
    n_checks++;
    if (vcnt - v0 !== 1) begin
      n_fail++; $display("FAIL rstmid_next_count: got %0d want 1", vcnt - v0);
    end
    n_checks++;
    if (data !== 8'h3C) begin
      n_fail++; $display("FAIL rstmid_next_data: got %h want 3C", data);
    end
  endtask

  task automatic test_break();
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    rx = 1'b0;
    wait_clks(30 * BitClks);
    rx = 1'b1;
    wait_clks(BitClks);
    n_checks++;
    if (ecnt - e0 !== 1) begin
      n_fail++; $display("FAIL break_ferr_count: got %0d want 1", ecnt - e0);
    end
    n_checks++;
    if (vcnt - v0 !== 0) begin
      n_fail++; $display("FAIL break_valid: got %0d want 0", vcnt - v0);
    end
    v0 = vcnt;
    send_frame(8'h0D, 1'b1);
    wait_clks(8);
    n_checks++;
    if (vcnt - v0 !== 1) begin
      n_fail++; $display("FAIL break_next_count: got %0d want 1", vcnt - v0);
    end
    n_checks++;
    if (data !== 8'h0D) begin
      n_fail++; $display("FAIL break_next_data: got %h want 0D", data);
    end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (both !== 0) begin
      n_fail++; $display("FAIL strobes_exclusive: got %0d overlaps want 0", both);
    end
  endtask

  initial begin
    rx    = 1'b1;
    rst_n = 1'b1;
    test_reset();
    test_good_byte();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
